ysyx_210184_mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single core-side memory bus (r_ena/w_ena/addr/ready) between instruction fetch and the MEM-stage load/store port.
- Registers the bus command and holds it stable until the bus completes, then returns a one-cycle response to the winning requester.
- Gives MEM priority, with a starvation counter that guarantees IF forward progress.
- Sits between the pipeline (IF, MEM stages) and the AXI4 bridge.

---
 rtl/ysyx_210184_mem_arbiter_pkg.sv | 19 +
 rtl/ysyx_210184_arb_starve_cnt.sv | 36 +++
 rtl/ysyx_210184_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ysyx_210184_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210184_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_210184_mem_arbiter_pkg
// Shared definitions for the IF/MEM memory-bus arbiter: FSM state encoding and
// the fixed widths of the instruction word and the byte-enable mask.
// ----------------------------------------------------------------------------
package ysyx_210184_mem_arbiter_pkg;

    localparam int REG_BUS = 64;   // default bus data width
    localparam int INS_BUS = 32;   // instruction word width
    localparam int MASK_W  = 8;    // byte-enable mask width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ysyx_210184_arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// ysyx_210184_arb_starve_cnt
// Saturating counter of consecutive MEM grants made while IF was waiting.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_inc          : count one MEM grant (holds once the limit is reached)
//   i_clr          : clear to zero (wins over i_inc)
//   o_at_limit     : counter equals LIMIT, IF must win the next arbitration
// ----------------------------------------------------------------------------
module ysyx_210184_arb_starve_cnt
    import ysyx_210184_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [3:0] r_cnt;

    assign o_at_limit = (r_cnt == 4'(LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/ysyx_210184_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_210184_mem_arbiter
// Shares the single core-side memory bus between instruction fetch (IF) and
// the MEM-stage load/store port. MEM has priority; a starvation counter forces
// an IF grant after STARVE_LIMIT consecutive MEM grants with IF waiting.
// The granted command is registered and held until the bus completes, then a
// one-cycle valid pulse is returned to the winner.
// Ports:
//   i_clk, i_rst_n               : clock, asynchronous active-low reset
//   i_if_req/i_if_addr           : fetch request (level) and address
//   o_if_valid/o_if_rdata        : fetch done pulse, selected 32-bit word
//   i_mem_req/we/addr/wdata/wmask: load/store request (level) and payload
//   o_mem_valid/o_mem_rdata      : load/store done pulse, raw 64-bit data
//   o_bus_*                      : command to the AXI bridge
//   i_bus_r_data/r_ready/w_ready : bridge response
//   o_busy                       : arbiter not idle
// ----------------------------------------------------------------------------
module ysyx_210184_mem_arbiter
    import ysyx_210184_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = REG_BUS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_valid,
    output logic [INS_BUS-1:0]  o_if_rdata,
    input  logic                i_mem_req,
    input  logic                i_mem_we,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    input  logic [MASK_W-1:0]   i_mem_wmask,
    output logic                o_mem_valid,
    output logic [DATA_W-1:0]   o_mem_rdata,
    output logic                o_bus_r_ena,
    output logic                o_bus_w_ena,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_w_data,
    output logic [MASK_W-1:0]   o_bus_w_mask,
    input  logic [DATA_W-1:0]   i_bus_r_data,
    input  logic                i_bus_r_ready,
    input  logic                i_bus_w_ready,
    output logic                o_busy
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic                r_bus_r_ena;
    logic                r_bus_w_ena;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_w_data;
    logic [MASK_W-1:0]   r_bus_w_mask;
    logic [INS_BUS-1:0]  r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_valid;
    logic                r_mem_valid;

    logic w_idle;
    logic w_at_limit;
    logic w_grant_mem;
    logic w_grant_if;
    logic w_done;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_grant_mem = i_mem_req && !(i_if_req && w_at_limit);
    assign w_grant_if  = i_if_req && !w_grant_mem;
    // Only the ready matching the outstanding command type completes it;
    // IF commands are always reads, so r_bus_w_ena is 0 for them.
    assign w_done      = r_bus_w_ena ? i_bus_w_ready : i_bus_r_ready;

    ysyx_210184_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (w_idle && w_grant_mem && i_if_req),
        .i_clr      (w_idle && (w_grant_if || !i_if_req)),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_mem) begin
                    w_state_nxt = ST_MEM_BUSY;
                end else if (w_grant_if) begin
                    w_state_nxt = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_r_ena  <= 1'b0;
            r_bus_w_ena  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_w_data <= '0;
            r_bus_w_mask <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_valid   <= 1'b0;
            r_mem_valid  <= 1'b0;
        end else begin
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_mem) begin
                        r_bus_addr   <= i_mem_addr;
                        r_bus_w_data <= i_mem_wdata;
                        r_bus_w_mask <= i_mem_wmask;
                        r_bus_w_ena  <= i_mem_we;
                        r_bus_r_ena  <= !i_mem_we;
                    end else if (w_grant_if) begin
                        r_bus_addr   <= i_if_addr;
                        r_bus_w_data <= '0;
                        r_bus_w_mask <= '0;
                        r_bus_w_ena  <= 1'b0;
                        r_bus_r_ena  <= 1'b1;
                    end
                end
                ST_IF_BUSY: begin
                    if (w_done) begin
                        r_bus_r_ena <= 1'b0;
                        r_if_rdata  <= r_bus_addr[2] ? i_bus_r_data[63:32]
                                                     : i_bus_r_data[31:0];
                        r_if_valid  <= 1'b1;
                    end
                end
                ST_MEM_BUSY: begin
                    if (w_done) begin
                        r_bus_r_ena <= 1'b0;
                        r_bus_w_ena <= 1'b0;
                        // Stores carry no read data; keep the last load value.
                        if (!r_bus_w_ena) begin
                            r_mem_rdata <= i_bus_r_data;
                        end
                        r_mem_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_bus_r_ena  = r_bus_r_ena;
    assign o_bus_w_ena  = r_bus_w_ena;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_w_data = r_bus_w_data;
    assign o_bus_w_mask = r_bus_w_mask;
    assign o_if_rdata   = r_if_rdata;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_if_valid   = r_if_valid;
    assign o_mem_valid  = r_mem_valid;
    assign o_busy       = !w_idle;

endmodule

// File: tb/tb_ysyx_210184_mem_arbiter.sv
module tb_ysyx_210184_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        bus_r_ena;
    logic        bus_w_ena;
    logic [63:0] bus_addr;
    logic [63:0] bus_w_data;
    logic [7:0]  bus_w_mask;
    logic [63:0] bus_r_data;
    logic        bus_r_ready;
    logic        bus_w_ready;
    logic        busy;

    always #5 clk = ~clk;

    ysyx_210184_mem_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_if_req      (if_req),
        .i_if_addr     (if_addr),
        .o_if_valid    (if_valid),
        .o_if_rdata    (if_rdata),
        .i_mem_req     (mem_req),
        .i_mem_we      (mem_we),
        .i_mem_addr    (mem_addr),
        .i_mem_wdata   (mem_wdata),
        .i_mem_wmask   (mem_wmask),
        .o_mem_valid   (mem_valid),
        .o_mem_rdata   (mem_rdata),
        .o_bus_r_ena   (bus_r_ena),
        .o_bus_w_ena   (bus_w_ena),
        .o_bus_addr    (bus_addr),
        .o_bus_w_data  (bus_w_data),
        .o_bus_w_mask  (bus_w_mask),
        .i_bus_r_data  (bus_r_data),
        .i_bus_r_ready (bus_r_ready),
        .i_bus_w_ready (bus_w_ready),
        .o_busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who holds the bus, what command it carries,
    // when the response pulse is due and what data it must carry.
    bit          m_idle, wait_idle, m_cmd_act, m_we, m_is_mem;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_mask;
    int          starve, rsp_cnt, v_due;
    logic [63:0] v_exp;
    bit          v_chk;

    // Requesters and bus responder controls.
    bit          if_act, mem_act, mem_repeat, rand_mode, stray_en;
    logic [63:0] if_a, mem_a, mem_wd;
    logic [7:0]  mem_m;
    bit          mem_w;
    int          rsp_delay;
    bit          rsp_rand_delay, rsp_fixed;
    logic [63:0] rsp_val;
    int          seen_valid;
    int          vlog[$];

    task automatic tick();
        logic [63:0] d;
        @(negedge clk);
        seen_valid = 0;

        // ---- compare DUT against the model ----
        chk1("busy", busy, !m_idle);
        chk1("bus_r_ena", bus_r_ena, m_cmd_act && !m_we);
        chk1("bus_w_ena", bus_w_ena, m_cmd_act && m_we);
        if (m_cmd_act) begin
            chk64("bus_addr", bus_addr, m_addr);
            chk64("bus_w_data", bus_w_data, m_wdata);
            chk64("bus_w_mask", {56'd0, bus_w_mask}, {56'd0, m_mask});
        end
        chk1("if_valid", if_valid, v_due == 1);
        chk1("mem_valid", mem_valid, v_due == 2);
        if (if_valid === 1'b1) begin seen_valid |= 1; vlog.push_back(1); end
        if (mem_valid === 1'b1) begin seen_valid |= 2; vlog.push_back(2); end
        if (v_due == 1) begin
            chk64("if_rdata", {32'd0, if_rdata}, v_exp);
            if_act    = 0;
            wait_idle = 1;
        end
        if (v_due == 2) begin
            if (v_chk) chk64("mem_rdata", mem_rdata, v_exp);
            mem_act   = mem_repeat;
            wait_idle = 1;
        end
        v_due = 0;

        // ---- bus responder ----
        bus_r_ready = 1'b0;
        bus_w_ready = 1'b0;
        if (m_cmd_act) begin
            if (rsp_cnt == 0) begin
                d = rsp_fixed ? rsp_val : {$urandom, $urandom};
                bus_r_data = d;
                if (m_we) bus_w_ready = 1'b1;
                else      bus_r_ready = 1'b1;
                v_due = m_is_mem ? 2 : 1;
                v_chk = !m_we;
                v_exp = m_is_mem ? d : {32'd0, (m_addr[2] ? d[63:32] : d[31:0])};
                m_cmd_act = 0;
            end else begin
                rsp_cnt--;
                if (stray_en && $urandom_range(0, 2) == 0) begin
                    if (m_we) bus_r_ready = 1'b1;
                    else      bus_w_ready = 1'b1;
                    bus_r_data = {$urandom, $urandom};
                end
            end
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) bus_r_ready = 1'b1;
            else                           bus_w_ready = 1'b1;
        end

        // ---- requesters ----
        if (rand_mode) begin
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1;
                if_a   = {$urandom, $urandom} & ~64'h3;
            end
            if (!mem_act && $urandom_range(0, 2) == 0) begin
                mem_act = 1;
                mem_a   = {$urandom, $urandom};
                mem_wd  = {$urandom, $urandom};
                mem_m   = 8'($urandom);
                mem_w   = ($urandom_range(0, 1) == 1);
            end
        end
        if_req    = if_act;
        if_addr   = if_a;
        mem_req   = mem_act;
        mem_we    = mem_w;
        mem_addr  = mem_a;
        mem_wdata = mem_wd;
        mem_wmask = mem_m;

        // ---- arbitration decision at the coming clock edge ----
        if (m_idle) begin
            if (!if_req) starve = 0;
            if (mem_req && !(if_req && starve == LIMIT)) begin
                if (if_req && starve < LIMIT) starve++;
                m_is_mem = 1; m_we = mem_we; m_addr = mem_addr;
                m_wdata  = mem_wdata; m_mask = mem_wmask;
            end else if (if_req) begin
                starve   = 0;
                m_is_mem = 0; m_we = 0; m_addr = if_addr;
                m_wdata  = 64'd0; m_mask = 8'd0;
            end
            if (mem_req || if_req) begin
                m_idle    = 0;
                m_cmd_act = 1;
                rsp_cnt   = rsp_rand_delay ? int'($urandom_range(0, 4)) : rsp_delay;
            end
        end else if (wait_idle) begin
            wait_idle = 0;
            m_idle    = 1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!(m_idle && !if_act && !mem_act) && n < 200) begin
            tick();
            n++;
        end
        chk1("drain_timeout", (n < 200), 1'b1);
        tick();
        tick();
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
        int          delay;
        bit          stray;
        logic [63:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  n;
        bit  done;
        int  nmem;

        vecs[0] = '{0, 0, 64'h0000_0000_8000_0004, 64'd0, 8'h00, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0000_0000_1234_5678, 2};
        vecs[1] = '{0, 0, 64'h0000_0000_8000_0000, 64'd0, 8'h00, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0000_0000_9ABC_DEF0, 2};
        vecs[2] = '{1, 0, 64'h0000_0000_8000_1000, 64'd0, 8'hFF, 64'hFEDC_BA98_7654_3210, 2, 0, 64'hFEDC_BA98_7654_3210, 4};
        vecs[3] = '{1, 1, 64'h0000_0000_8000_2008, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'd0, 5, 1, 64'd0, 7};
        vecs[4] = '{1, 1, 64'h0000_0000_8000_2010, 64'h0000_0000_0000_0001, 8'h00, 64'd0, 1, 0, 64'd0, 3};
        vecs[5] = '{0, 0, 64'h0000_0000_8000_300C, 64'd0, 8'h00, 64'hCAFE_F00D_0BAD_BEEF, 3, 1, 64'h0000_0000_CAFE_F00D, 5};

        m_idle = 1; wait_idle = 0; m_cmd_act = 0; m_we = 0; m_is_mem = 0;
        m_addr = 0; m_wdata = 0; m_mask = 0; starve = 0; rsp_cnt = 0; v_due = 0;
        v_exp = 0; v_chk = 0;
        if_act = 0; mem_act = 0; mem_repeat = 0; rand_mode = 0; stray_en = 0;
        if_a = 0; mem_a = 0; mem_wd = 0; mem_m = 0; mem_w = 0;
        rsp_delay = 0; rsp_rand_delay = 0; rsp_fixed = 1; rsp_val = 0;

        rst_n = 1'b0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
        mem_wdata = 0; mem_wmask = 0;
        bus_r_data = 0; bus_r_ready = 0; bus_w_ready = 0;

        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_r_ena", bus_r_ena, 1'b0);
        chk1("rst_w_ena", bus_w_ena, 1'b0);
        chk64("rst_addr", bus_addr, 64'd0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_mem_valid", mem_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();

        // ---- directed single transactions ----
        for (int k = 0; k < 6; k++) begin
            rsp_delay = vecs[k].delay; rsp_rand_delay = 0;
            rsp_fixed = 1; rsp_val = vecs[k].rdata; stray_en = vecs[k].stray;
            if (vecs[k].is_mem) begin
                mem_act = 1; mem_a = vecs[k].addr; mem_w = vecs[k].we;
                mem_wd = vecs[k].wdata; mem_m = vecs[k].mask;
            end else begin
                if_act = 1; if_a = vecs[k].addr;
            end
            tick();
            n = 0; done = 0;
            while (!done && n < 40) begin
                tick();
                n++;
                if (n == 1) begin
                    chk64("vec_bus_addr", bus_addr, vecs[k].addr);
                    chk1("vec_w_ena", bus_w_ena, vecs[k].we);
                    chk64("vec_w_mask", {56'd0, bus_w_mask}, {56'd0, vecs[k].mask});
                end
                if (seen_valid != 0) done = 1;
            end
            chk64("vec_latency", 64'(n), 64'(vecs[k].exp_lat));
            if (!vecs[k].is_mem)      chk64("vec_if_rdata", {32'd0, if_rdata}, vecs[k].exp_data);
            else if (!vecs[k].we)     chk64("vec_mem_rdata", mem_rdata, vecs[k].exp_data);
            stray_en = 0;
            tick();
            tick();
        end

        // ---- simultaneous requests: MEM first, then IF ----
        rsp_delay = 0; rsp_fixed = 0;
        vlog.delete();
        if_act = 1; if_a = 64'h8000_0100;
        mem_act = 1; mem_a = 64'h8000_1000; mem_w = 0; mem_m = 8'h00; mem_wd = 0;
        n = 0;
        while (vlog.size() < 2 && n < 40) begin tick(); n++; end
        chk64("simul_count", 64'(vlog.size()), 64'd2);
        if (vlog.size() >= 2) begin
            chk64("simul_first", 64'(vlog[0]), 64'd2);
            chk64("simul_second", 64'(vlog[1]), 64'd1);
        end
        drain();

        // ---- starvation: continuous MEM, IF forced after LIMIT grants ----
        vlog.delete();
        mem_repeat = 1; mem_act = 1; mem_w = 0; mem_a = 64'h8000_4000;
        if_act = 1; if_a = 64'h8000_0200;
        n = 0;
        while (!(vlog.size() > 0 && vlog[vlog.size()-1] == 1) && n < 100) begin
            tick();
            n++;
        end
        chk1("starve_mem_req_high", mem_req, 1'b1);
        mem_repeat = 0;
        nmem = 0;
        foreach (vlog[i]) if (vlog[i] == 2) nmem++;
        chk64("starve_mem_grants", 64'(nmem), 64'(LIMIT));
        chk64("starve_total", 64'(vlog.size()), 64'(LIMIT + 1));
        drain();

        // ---- reset in the middle of a store ----
        rsp_delay = 10;
        mem_act = 1; mem_w = 1; mem_a = 64'h8000_5000; mem_wd = 64'h1111_2222_3333_4444; mem_m = 8'hF0;
        tick(); tick(); tick();
        chk1("pre_rst_w_ena", bus_w_ena, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_w_ena", bus_w_ena, 1'b0);
        chk1("arst_r_ena", bus_r_ena, 1'b0);
        chk64("arst_addr", bus_addr, 64'd0);
        chk64("arst_w_data", bus_w_data, 64'd0);
        chk64("arst_w_mask", {56'd0, bus_w_mask}, 64'd0);
        chk64("arst_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk64("arst_mem_rdata", mem_rdata, 64'd0);
        chk1("arst_mem_valid", mem_valid, 1'b0);
        m_idle = 1; wait_idle = 0; m_cmd_act = 0; v_due = 0; starve = 0;
        if_act = 0; mem_act = 0; if_req = 0; mem_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_w_ready = 1'b1;
        bus_r_ready = 1'b1;
        repeat (4) tick();

        // ---- randomized traffic against the model ----
        rand_mode = 1; stray_en = 1; rsp_rand_delay = 1; rsp_fixed = 0;
        repeat (2000) tick();
        rand_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
